// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the piso_tx transmitter
//   state_t       : FSM state encoding (IDLE, SHIFT, PAR; PAR is only used
//                   when PISO_TX_PARITY_EN is defined)
//   cnt_w()       : width of the bit counter for a given word width
//   DEFAULT_WIDTH : default data word width
package piso_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// rtl/piso_hold_buf.sv - one-entry holding buffer in front of the shift register
//   clk, rst  : clock, asynchronous active-low reset
//   din       : word offered by the source
//   din_valid : din holds a word
//   din_ready : buffer empty; a word is taken on an edge with din_valid && din_ready
//   dout      : buffered word
//   full      : buffer holds a word
//   pop       : consumer takes dout this edge (only meaningful while full)
module piso_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  input  logic             pop
);

  // Ready comes straight from the flag, so there is no path from din_valid.
  assign din_ready = !full;

  // Push needs an empty buffer and pop needs a full one, so they never coincide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      dout <= '0;
    end else if (din_valid && !full) begin
      dout <= din;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with one-word holding buffer
//   Optional macro PISO_TX_PARITY_EN appends an even-parity bit to each frame.
//   clk, rst    : clock, asynchronous active-low reset
//   din         : WIDTH-bit parallel word
//   din_valid   : din holds a word to send
//   din_ready   : holding buffer empty
//   so          : serial data (0 whenever so_valid is low)
//   so_valid    : so carries a frame bit
//   frame_start : first bit of a frame
//   frame_done  : last bit of a frame (the parity bit when parity is enabled)
//   busy        : FSM not idle or holding buffer full
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int              CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shift;
  logic [WIDTH-1:0] hb;
  logic             hb_full;
  logic             hb_pop;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             data_bit;

  piso_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .dout     (hb),
    .full     (hb_full),
    .pop      (hb_pop)
  );

  assign last_bit = (cnt == LAST);

  // The bit on so always sits at the output end of sr; shift toward that end.
  assign data_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];
  assign sr_shift = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

  // Every sr load is a pop of the holding buffer; the FSM uses hb_pop as its
  // load strobe so the two can never disagree.
  always_comb begin
    hb_pop = 1'b0;
    case (state)
      IDLE:  hb_pop = hb_full;
`ifdef PISO_TX_PARITY_EN
      PAR:   hb_pop = hb_full;
`else
      SHIFT: hb_pop = hb_full && last_bit;
`endif
      default: hb_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hb_pop) begin
            sr    <= hb;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!last_bit) begin
            sr  <= sr_shift;
            cnt <= cnt + CW'(1);
          end else begin
            cnt <= '0;
`ifdef PISO_TX_PARITY_EN
            sr    <= sr_shift;
            state <= PAR;
`else
            // Reload on the last-bit edge keeps back-to-back frames gapless.
            if (hb_pop) begin
              sr <= hb;
            end else begin
              sr    <= sr_shift;
              state <= IDLE;
            end
`endif
          end
        end
`ifdef PISO_TX_PARITY_EN
        PAR: begin
          cnt <= '0;
          if (hb_pop) begin
            sr    <= hb;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
`endif
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PISO_TX_PARITY_EN
  // Parity of the word entering sr, captured alongside the load.
  logic par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (hb_pop) begin
      par <= ^hb;
    end
  end

  assign so          = (state == SHIFT) ? data_bit : ((state == PAR) ? par : 1'b0);
  assign so_valid    = (state == SHIFT) || (state == PAR);
  assign frame_done  = (state == PAR);
`else
  assign so          = (state == SHIFT) ? data_bit : 1'b0;
  assign so_valid    = (state == SHIFT);
  assign frame_done  = (state == SHIFT) && last_bit;
`endif

  assign frame_start = (state == SHIFT) && (cnt == '0);
  assign busy        = (state != IDLE) || hb_full;

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - directed self-checking bench for piso_tx (MSB-first and LSB-first instances)
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready, so, so_valid, frame_start, frame_done, busy;
  logic [3:0] din_l;
  logic       din_valid_l;
  logic       din_ready_l, so_l, so_valid_l, frame_start_l, frame_done_l, busy_l;

  int n_checks = 0;
  int n_pass   = 0;

  logic       bits[$];
  logic       starts[$];
  logic       dones[$];
  int         runs;
  logic       prev_v;
  logic [3:0] exp_words[$];

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .so(so), .so_valid(so_valid), .frame_start(frame_start), .frame_done(frame_done),
    .busy(busy)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
    .so(so_l), .so_valid(so_valid_l), .frame_start(frame_start_l),
    .frame_done(frame_done_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [3:0] w, input int i, input bit msb);
    if (i >= 4) return ^w;
    return msb ? w[3-i] : w[i];
  endfunction

  // Records every frame bit of the MSB-first instance, sampled 1ns after the edge.
  initial begin
    prev_v = 1'b0;
    runs   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (so_valid) begin
        bits.push_back(so);
        starts.push_back(frame_start);
        dones.push_back(frame_done);
        if (!prev_v) runs++;
      end
      prev_v = so_valid;
    end
  end

  task automatic clear_mon();
    bits.delete();
    starts.delete();
    dones.delete();
    runs = 0;
    exp_words.delete();
  endtask

  task automatic push(input logic [3:0] w, output int edges);
    logic rdy;
    edges     = 0;
    din       = w;
    din_valid = 1'b1;
    do begin
      rdy = din_ready;
      tick();
      edges++;
    end while (!rdy && edges < 100);
    din_valid = 1'b0;
    if (!rdy) check("push_timeout", rdy, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    check({tag, "_so_zero"}, so, 0);
  endtask

  // Compares the recorded stream against exp_words; a 4-bit MSB-first
  // receiver shifting the data bits must reassemble each word.
  task automatic check_stream(input string tag);
    int         nw;
    logic [3:0] q;
    nw = exp_words.size();
    check({tag, "_len"}, bits.size(), nw * FL);
    check({tag, "_runs"}, runs, 1);
    if (bits.size() == nw * FL) begin
      for (int f = 0; f < nw; f++) begin
        q = '0;
        for (int i = 0; i < FL; i++) begin
          check($sformatf("%s_f%0d_b%0d", tag, f, i), bits[f*FL+i], exp_bit(exp_words[f], i, 1'b1));
          check($sformatf("%s_f%0d_start%0d", tag, f, i), starts[f*FL+i], (i == 0));
          check($sformatf("%s_f%0d_done%0d", tag, f, i), dones[f*FL+i], (i == FL-1));
          if (i < 4) q = {q[2:0], bits[f*FL+i]};
        end
        check($sformatf("%s_rx%0d", tag, f), q, exp_words[f]);
      end
    end
  endtask

  initial begin
    int e;
    rst = 1'b0; din = '0; din_valid = 1'b0; din_l = '0; din_valid_l = 1'b0;

    // reset
    tick(); tick();
    check("rst_ready", din_ready, 1);
    check("rst_so_valid", so_valid, 0);
    check("rst_so", so, 0);
    check("rst_busy", busy, 0);
    check("rst_fs_fd", {frame_start, frame_done}, 0);
    rst = 1'b1;
    tick(); tick(); tick();
    check("post_rst_ready", din_ready, 1);
    check("post_rst_so_valid", so_valid, 0);
    check("post_rst_busy", busy, 0);

    // single word, latency
    clear_mon();
    din = 4'b1001; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check("lat_so_valid", so_valid, 0);
    check("lat_ready", din_ready, 0);
    check("lat_busy", busy, 1);
    tick();
    check("first_so_valid", so_valid, 1);
    check("first_so", so, 1);
    check("first_start", frame_start, 1);
    wait_idle("single");
    exp_words.push_back(4'b1001);
    check_stream("single");

    // back-to-back
    clear_mon();
    push(4'b1001, e);
    push(4'b0110, e);
    check("b2b_second_edges", e, 2);
    wait_idle("b2b");
    exp_words.push_back(4'b1001);
    exp_words.push_back(4'b0110);
    check_stream("b2b");

    // backpressure: third word waits for the reload
    clear_mon();
    push(4'b1010, e);
    push(4'b0011, e);
    check("bp_ready_low", din_ready, 0);
    check("bp_busy", busy, 1);
    push(4'b1100, e);
    check("bp_wait_edges", e, FL);
    wait_idle("bp");
    exp_words.push_back(4'b1010);
    exp_words.push_back(4'b0011);
    exp_words.push_back(4'b1100);
    check_stream("bp");

    // reset mid-frame during bit 2
    clear_mon();
    push(4'b1100, e);
    tick(); tick(); tick();
    check("mid_in_frame", so_valid, 1);
    check("mid_bit2", so, 0);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_so_valid", so_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", din_ready, 1);
    tick();
    rst = 1'b1;
    tick();
    clear_mon();
    push(4'b1111, e);
    wait_idle("after_rst");
    exp_words.push_back(4'b1111);
    check_stream("after_rst");

    // LSB-first instance
    din_l = 4'b1011; din_valid_l = 1'b1;
    tick();
    din_valid_l = 1'b0;
    check("lsb_lat", so_valid_l, 0);
    for (int i = 0; i < FL; i++) begin
      tick();
      check($sformatf("lsb_valid%0d", i), so_valid_l, 1);
      check($sformatf("lsb_b%0d", i), so_l, exp_bit(4'b1011, i, 1'b0));
      check($sformatf("lsb_start%0d", i), frame_start_l, (i == 0));
      check($sformatf("lsb_done%0d", i), frame_done_l, (i == FL-1));
    end
    tick();
    check("lsb_end_valid", so_valid_l, 0);
    check("lsb_end_busy", busy_l, 0);
    check("lsb_end_ready", din_ready_l, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
